// File: rtl/capture_checker.sv
// Captures DEPTH DUT samples after ALIGN_CYCLES, counts mismatches against i_expected, then dumps the buffer.
// Latency: done S+ALIGN+2*DEPTH with ready held high; dump words hold stable while i_dump_ready is low.
module capture_checker #(
    parameter int DATA_W       = 8,
    parameter int DEPTH        = 16,
    parameter int ALIGN_CYCLES = 0,
    localparam int IDX_W       = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [DATA_W-1:0] i_out,
    input  logic [DATA_W-1:0] i_expected,
    input  logic              i_check_en,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_pass,
    output logic [15:0]       o_error_count,
    output logic              o_first_err_seen,
    output logic [IDX_W-1:0]  o_first_err_idx,
    output logic              o_dump_valid,
    output logic [DATA_W-1:0] o_dump_data,
    output logic [IDX_W-1:0]  o_dump_idx,
    output logic              o_dump_last,
    input  logic              i_dump_ready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ALIGN,
        S_CAPTURE,
        S_DUMP,
        S_DONE
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(DEPTH - 1);
    localparam logic [3:0]       ALIGN_LOAD = 4'(ALIGN_CYCLES);

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        align_cnt;
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_idx;
    logic [15:0]       err_cnt;
    logic              first_seen;
    logic [IDX_W-1:0]  first_idx;
    logic [DATA_W-1:0] buf_mem [DEPTH];

    logic start_ok;
    logic capture;
    logic mismatch;
    logic dump_fire;

    assign start_ok  = i_start && (state == S_IDLE || state == S_DONE);
    assign capture   = (state == S_CAPTURE);
    assign mismatch  = capture && i_check_en && (i_out != i_expected);
    assign dump_fire = (state == S_DUMP) && i_dump_ready;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt        = state;
        o_busy           = 1'b0;
        o_done           = 1'b0;
        o_pass           = 1'b0;
        o_error_count    = err_cnt;
        o_first_err_seen = first_seen;
        o_first_err_idx  = first_idx;
        o_dump_valid     = 1'b0;
        o_dump_data      = '0;
        o_dump_idx       = '0;
        o_dump_last      = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_start) begin
                    state_nxt = (ALIGN_CYCLES > 0) ? S_ALIGN : S_CAPTURE;
                end
            end
            S_ALIGN: begin
                o_busy = 1'b1;
                // Load value was ALIGN_CYCLES, so leaving at count 1 spends exactly that many cycles here.
                if (align_cnt <= 4'd1) begin
                    state_nxt = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                o_busy = 1'b1;
                if (wr_idx == LAST_IDX) begin
                    state_nxt = S_DUMP;
                end
            end
            S_DUMP: begin
                o_busy       = 1'b1;
                o_dump_valid = 1'b1;
                o_dump_data  = buf_mem[rd_idx];
                o_dump_idx   = rd_idx;
                o_dump_last  = (rd_idx == LAST_IDX);
                if (i_dump_ready && rd_idx == LAST_IDX) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                o_done = 1'b1;
                o_pass = (err_cnt == 16'd0);
                if (i_start) begin
                    state_nxt = (ALIGN_CYCLES > 0) ? S_ALIGN : S_CAPTURE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            align_cnt  <= '0;
            wr_idx     <= '0;
            rd_idx     <= '0;
            err_cnt    <= '0;
            first_seen <= 1'b0;
            first_idx  <= '0;
        end else if (start_ok) begin
            align_cnt  <= ALIGN_LOAD;
            wr_idx     <= '0;
            rd_idx     <= '0;
            err_cnt    <= '0;
            first_seen <= 1'b0;
            first_idx  <= '0;
        end else begin
            if (state == S_ALIGN && align_cnt != 4'd0) begin
                align_cnt <= align_cnt - 4'd1;
            end
            if (capture && wr_idx != LAST_IDX) begin
                wr_idx <= wr_idx + 1'b1;
            end
            if (mismatch) begin
                if (err_cnt != 16'hFFFF) begin
                    err_cnt <= err_cnt + 16'd1;
                end
                if (!first_seen) begin
                    first_seen <= 1'b1;
                    first_idx  <= wr_idx;
                end
            end
            if (dump_fire && rd_idx != LAST_IDX) begin
                rd_idx <= rd_idx + 1'b1;
            end
        end
    end

    // Not reset: every entry is rewritten during CAPTURE before DUMP can read it.
    always_ff @(posedge i_clk) begin
        if (capture) begin
            buf_mem[wr_idx] <= i_out;
        end
    end

endmodule

// File: tb/tb_capture_checker.sv
// Bench for capture_checker: table-driven runs on a DEPTH=4/ALIGN=0 instance, randomized runs on both
// instances (second is DEPTH=8/ALIGN=2) scored against a queue-based model, plus reset and align sequences.
module tb_capture_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start_a, start_b;
    logic [7:0] out_s, exp_s;
    logic       chk_s, rdy_s;

    logic       busy_a, done_a, pass_a, seen_a, vld_a, last_a;
    logic [15:0] cnt_a;
    logic [1:0] fidx_a, didx_a;
    logic [7:0] ddat_a;
    logic       busy_b, done_b, pass_b, seen_b, vld_b, last_b;
    logic [15:0] cnt_b;
    logic [2:0] fidx_b, didx_b;
    logic [7:0] ddat_b;

    capture_checker #(.DATA_W(8), .DEPTH(4), .ALIGN_CYCLES(0)) dut_a (
        .i_clk(clk), .i_reset(rst), .i_start(start_a), .i_out(out_s), .i_expected(exp_s),
        .i_check_en(chk_s), .o_busy(busy_a), .o_done(done_a), .o_pass(pass_a),
        .o_error_count(cnt_a), .o_first_err_seen(seen_a), .o_first_err_idx(fidx_a),
        .o_dump_valid(vld_a), .o_dump_data(ddat_a), .o_dump_idx(didx_a), .o_dump_last(last_a),
        .i_dump_ready(rdy_s)
    );

    capture_checker #(.DATA_W(8), .DEPTH(8), .ALIGN_CYCLES(2)) dut_b (
        .i_clk(clk), .i_reset(rst), .i_start(start_b), .i_out(out_s), .i_expected(exp_s),
        .i_check_en(chk_s), .o_busy(busy_b), .o_done(done_b), .o_pass(pass_b),
        .o_error_count(cnt_b), .o_first_err_seen(seen_b), .o_first_err_idx(fidx_b),
        .o_dump_valid(vld_b), .o_dump_data(ddat_b), .o_dump_idx(didx_b), .o_dump_last(last_b),
        .i_dump_ready(rdy_s)
    );

    int sel;
    logic        busy, done, pass, seen, vld, last;
    logic [15:0] cnt;
    logic [7:0]  fidx, didx, ddat;

    always_comb begin
        if (sel == 0) begin
            {busy, done, pass, seen, vld, last} = {busy_a, done_a, pass_a, seen_a, vld_a, last_a};
            cnt = cnt_a; fidx = {6'd0, fidx_a}; didx = {6'd0, didx_a}; ddat = ddat_a;
        end else begin
            {busy, done, pass, seen, vld, last} = {busy_b, done_b, pass_b, seen_b, vld_b, last_b};
            cnt = cnt_b; fidx = {5'd0, fidx_b}; didx = {5'd0, didx_b}; ddat = ddat_b;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (dut %0d, t=%0t)", name, act, req, sel, $time);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_pass"}, pass, 0);
        check({tag, "_cnt"}, cnt, 0);
        check({tag, "_seen"}, seen, 0);
        check({tag, "_fidx"}, fidx, 0);
        check({tag, "_vld"}, vld, 0);
        check({tag, "_ddat"}, ddat, 0);
        check({tag, "_didx"}, didx, 0);
        check({tag, "_last"}, last, 0);
    endtask

    // Stimulus stream (one entry per cycle after the start edge) and expected results.
    logic [7:0] s_out[$], s_exp[$], exp_dump[$];
    bit         s_chk[$], rdy_q[$];
    int         exp_cnt, exp_first;
    bit         exp_seen, exp_pass, pulse_start;

    task automatic model_expect(input int d, input int a);
        exp_dump.delete();
        exp_cnt = 0; exp_seen = 0; exp_first = 0;
        for (int j = 0; j < d; j++) begin
            exp_dump.push_back(s_out[a + j]);
            if (s_chk[a + j] && s_out[a + j] != s_exp[a + j]) begin
                exp_cnt++;
                if (!exp_seen) begin
                    exp_seen = 1; exp_first = j;
                end
            end
        end
        exp_pass = (exp_cnt == 0);
    endtask

    task automatic set_start(input logic v);
        if (sel == 0) start_a = v; else start_b = v;
    endtask

    task automatic run(input bit timing);
        int d, a, edges, ndump, ri;
        bit pend;
        logic [7:0] pd, pi;
        logic pl;
        d = (sel == 0) ? 4 : 8;
        a = (sel == 0) ? 0 : 2;
        @(negedge clk);
        set_start(1'b1);
        rdy_s = 1'b0;
        @(posedge clk); #1;
        set_start(1'b0);
        edges = 0;
        for (int k = 0; k < a + d; k++) begin
            out_s = s_out[k]; exp_s = s_exp[k]; chk_s = s_chk[k];
            if (pulse_start && k == a + 1) set_start(1'b1);
            @(negedge clk);
            check("busy_run", busy, 1);
            if (k == 0) begin
                check("cnt_cleared", cnt, 0);
                check("seen_cleared", seen, 0);
            end
            @(posedge clk); edges++; #1;
            set_start(1'b0);
        end
        ndump = 0; ri = 0; pend = 0; pd = '0; pi = '0; pl = 1'b0;
        forever begin
            rdy_s = (ri < rdy_q.size()) ? rdy_q[ri] : 1'b1;
            ri++;
            if (pulse_start && ndump == 1) set_start(1'b1);
            @(negedge clk);
            if (done || edges > 200) break;
            check("dump_valid", vld, 1);
            if (pend) begin
                check("hold_data", ddat, pd);
                check("hold_idx", didx, pi);
                check("hold_last", last, pl);
            end
            if (rdy_s) begin
                check("dump_data", ddat, (ndump < exp_dump.size()) ? exp_dump[ndump] : -1);
                check("dump_idx", didx, ndump);
                check("dump_last", last, (ndump == d - 1) ? 1 : 0);
                ndump++;
                pend = 0;
            end else begin
                pend = 1; pd = ddat; pi = didx; pl = last;
            end
            @(posedge clk); edges++; #1;
            set_start(1'b0);
        end
        check("done", done, 1);
        if (timing) check("done_edge", edges, a + 2 * d);
        check("dump_words", ndump, d);
        check("busy_after", busy, 0);
        check("vld_after", vld, 0);
        check("pass", pass, exp_pass);
        check("err_count", cnt, exp_cnt);
        check("first_seen", seen, exp_seen);
        check("first_idx", fidx, exp_first);
        pulse_start = 0;
        rdy_q.delete();
    endtask

    task automatic random_run(input int n_samples);
        s_out.delete(); s_exp.delete(); s_chk.delete(); rdy_q.delete();
        for (int k = 0; k < n_samples; k++) begin
            logic [7:0] v;
            v = 8'($urandom);
            s_out.push_back(v);
            s_exp.push_back(($urandom_range(0, 3) == 0) ? v ^ 8'(1 << $urandom_range(0, 7)) : v);
            s_chk.push_back($urandom_range(0, 4) != 0);
        end
        for (int k = 0; k < 20; k++) rdy_q.push_back($urandom_range(0, 9) < 7);
        pulse_start = $urandom_range(0, 1);
        model_expect((sel == 0) ? 4 : 8, (sel == 0) ? 0 : 2);
        run(1'b0);
    endtask

    typedef struct {
        logic [31:0] outs;
        logic [31:0] exps;
        logic [3:0]  chk;
        logic [7:0]  rdy;
        int          rdy_n;
        bit          pulse;
        int          cnt;
        bit          seen;
        int          first;
        bit          pass;
    } vec_t;

    vec_t tbl[5];

    initial begin
        tbl[0] = '{32'h40302211, 32'h44332211, 4'hF, 8'h00, 0, 1'b0, 2, 1'b1, 2, 1'b0};
        tbl[1] = '{32'h44332211, 32'h44332211, 4'hF, 8'h00, 0, 1'b0, 0, 1'b0, 0, 1'b1};
        tbl[2] = '{32'h40302211, 32'h44332211, 4'h3, 8'h00, 0, 1'b0, 0, 1'b0, 0, 1'b1};
        tbl[3] = '{32'h44332211, 32'h44332211, 4'hF, 8'h69, 7, 1'b1, 0, 1'b0, 0, 1'b1};
        tbl[4] = '{32'hFF3322A5, 32'h4433225A, 4'hF, 8'h00, 0, 1'b0, 2, 1'b1, 0, 1'b0};

        sel = 0; pulse_start = 0;
        start_a = 0; start_b = 0; out_s = '0; exp_s = '0; chk_s = 0; rdy_s = 0;
        rst = 1'b1;
        #2;
        check_idle("reset_a");
        sel = 1; #1;
        check_idle("reset_b");
        sel = 0;
        @(negedge clk); rst = 1'b0;

        // Reset pulse between edges while capturing with a mismatch already counted.
        @(negedge clk); start_a = 1'b1;
        @(posedge clk); #1; start_a = 1'b0;
        out_s = 8'h12; exp_s = 8'h34; chk_s = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("mid_busy", busy, 1);
        check("mid_cnt", cnt, 1);
        #1 rst = 1'b1;
        #1 check_idle("midrst");
        #1 rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            s_out.delete(); s_exp.delete(); s_chk.delete(); exp_dump.delete(); rdy_q.delete();
            for (int j = 0; j < 4; j++) begin
                s_out.push_back(tbl[i].outs[8*j +: 8]);
                s_exp.push_back(tbl[i].exps[8*j +: 8]);
                s_chk.push_back(tbl[i].chk[j]);
                exp_dump.push_back(tbl[i].outs[8*j +: 8]);
            end
            for (int j = 0; j < tbl[i].rdy_n; j++) rdy_q.push_back(tbl[i].rdy[j]);
            pulse_start = tbl[i].pulse;
            exp_cnt = tbl[i].cnt; exp_seen = tbl[i].seen;
            exp_first = tbl[i].first; exp_pass = tbl[i].pass;
            run(tbl[i].rdy_n == 0);
        end

        // Align window: 0xEE in the two ignored cycles, flagged as mismatches, must not count or be dumped.
        sel = 1;
        s_out.delete(); s_exp.delete(); s_chk.delete(); rdy_q.delete();
        for (int k = 0; k < 2; k++) begin
            s_out.push_back(8'hEE); s_exp.push_back(8'h00); s_chk.push_back(1'b1);
        end
        for (int k = 1; k <= 8; k++) begin
            s_out.push_back(8'(k)); s_exp.push_back(8'(k)); s_chk.push_back(1'b1);
        end
        exp_dump.delete();
        for (int k = 1; k <= 8; k++) exp_dump.push_back(8'(k));
        exp_cnt = 0; exp_seen = 0; exp_first = 0; exp_pass = 1;
        pulse_start = 1;
        run(1'b1);

        for (int r = 0; r < 6; r++) random_run(10);
        sel = 0;
        for (int r = 0; r < 6; r++) random_run(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/capture_checker.md
# capture_checker

Synthesizable response-side companion to the bench's vector reader: captures a DUT output stream into an internal buffer, compares each sample against a supplied expected value, and counts mismatches. After capture, it streams the buffered samples out over a valid/ready dump port. It sits beside the DUT, on the same clock as the vector source, and closes the loop that the reader opens.

## Interface
- DATA_W, 8, width of DUT output and expected samples
- DEPTH, 16, samples captured per run (2..256)
- ALIGN_CYCLES, 0, cycles ignored after start to absorb DUT latency (0..15)
- IDX_W, $clog2(DEPTH), index width (derived, not overridden)

Ports:
- i_clk  in  1  clock, rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_start  in  1  start a run; accepted only in IDLE or DONE
- i_out  in  DATA_W  DUT output sample
- i_expected  in  DATA_W  expected sample for the same cycle
- i_check_en  in  1  1 = compare this sample; 0 = capture only
- o_busy  out  1  high in ALIGN, CAPTURE, DUMP
- o_done  out  1  high in DONE
- o_pass  out  1  valid in DONE: error count is zero
- o_error_count  out  16  mismatch count, saturates at 0xFFFF
- o_first_err_seen  out  1  at least one mismatch this run
- o_first_err_idx  out  IDX_W  capture index of the first mismatch
- o_dump_valid  out  1  dump word available
- o_dump_data  out  DATA_W  buffered sample
- o_dump_idx  out  IDX_W  index of o_dump_data
- o_dump_last  out  1  o_dump_valid and o_dump_idx == DEPTH-1
- i_dump_ready  in  1  consumer accepts dump word

## Operation
- States: IDLE, ALIGN, CAPTURE, DUMP, DONE.
- IDLE: all outputs 0. i_start=1 clears the error count, the first-error flag/index, and the write and read indices. Next state is ALIGN if ALIGN_CYCLES>0, else CAPTURE.
- ALIGN: down-counter loaded with ALIGN_CYCLES. Samples are ignored. Moves to CAPTURE when the count reaches 0 (exactly ALIGN_CYCLES cycles spent in ALIGN).
- CAPTURE: each edge writes i_out to buf[wr_idx].
  - If i_check_en and i_out != i_expected (bitwise, all DATA_W bits), the error count increments (saturating).
  - On the first mismatch of a run, the block latches o_first_err_idx = wr_idx and sets o_first_err_seen.
  - After the write at wr_idx == DEPTH-1, the state moves to DUMP.
- DUMP: o_dump_valid=1, o_dump_data=buf[rd_idx], o_dump_idx=rd_idx.
  - On valid&&ready, rd_idx increments.
  - While ready is low, data, index and last hold stable.
  - After the handshake with o_dump_last=1, the state moves to DONE.
- DONE: o_done=1, o_pass=(o_error_count==0). Count and first-error outputs hold. i_start behaves as in IDLE.
- i_start is ignored in ALIGN, CAPTURE and DUMP.
- Reset (asynchronous, any state): state goes to IDLE; all counters, indices and outputs go to 0. Buffer contents are not reset; they are unobservable until fully rewritten.
- Buffer is a register array with combinational read by rd_idx. No X may reach o_dump_data during DUMP.

## Timing
- i_start sampled high at edge S. The first capture edge is S+1+ALIGN_CYCLES and the last is S+ALIGN_CYCLES+DEPTH.
- o_error_count and first-error outputs update on the capture edge of the offending sample and are visible the following cycle.
- o_dump_valid rises the cycle after the last capture edge.
- With i_dump_ready held at 1, one word transfers per cycle. o_done rises after edge S+ALIGN_CYCLES+2·DEPTH.
- o_busy is high from the edge after S until the edge entering DONE.
- Reset taking effect mid-run: outputs are 0 immediately (asynchronous). Operation resumes on the first edge after i_reset deasserts; i_start must then be reasserted.

## Test plan
- Reset: pulse i_reset between edges during CAPTURE -> all outputs 0 and o_busy=0 before the next edge; a later i_start runs a normal capture.
- DEPTH=4, ALIGN=0, i_out=i_expected=0x11,0x22,0x33,0x44, ready=1 -> dump 0x11,0x22,0x33,0x44 with idx 0..3, last on 0x44, o_done at edge S+8, o_pass=1, count=0.
- Same stream with i_out=0x30 at idx 2 and 0x40 at idx 3 -> count=2, first_err_idx=2, first_err_seen=1, o_pass=0; dump shows 0x11,0x22,0x30,0x40.
- The idx-2 and idx-3 mismatches with i_check_en=0 on both -> count=0, o_pass=1, captured data still dumped.
- Backpressure: ready pattern 1,0,0,1,0,1,1 -> every word transfers once, in order; data/idx/last stable while ready=0.
- ALIGN_CYCLES=2, 0xEE driven on the two cycles after start -> 0xEE never appears in the dump. i_start pulsed during CAPTURE/DUMP -> no effect. After DONE, i_start -> new run with count cleared.
